// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the architectural PC, sequences instruction
// memory requests, loads IF/ID and applies stalls, flushes and redirects.
module fetch_stage #(
   parameter logic [63:0] RESET_PC     = 64'h0,
   parameter logic [31:0] BUBBLE_INSTR = 32'hD503201F
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [63:0] NextPC,
   input  logic        PCSrc,
   input  logic        Stall,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic [63:0] CurrentPC,
   output logic [63:0] IFID_PC,
   output logic [31:0] IFID_Instr,
   output logic        IFID_Valid
);

   typedef enum logic [1:0] {START, FETCH, HOLD, DRAIN} state_t;

   state_t      state_q;
   logic [63:0] pc_q;
   logic [63:0] req_addr_q;
   logic [63:0] hold_pc_q;
   logic [31:0] hold_instr_q;
   logic [63:0] ifid_pc_q;
   logic [31:0] ifid_instr_q;
   logic        ifid_valid_q;

   // Redirect target is word aligned; sequential address wraps modulo 2^64.
   logic [63:0] target_d;
   logic [63:0] req_next_d;

   assign target_d   = {NextPC[63:2], 2'b00};
   assign req_next_d = req_addr_q + 64'd4;

   // Request is live while fetching or while draining a committed request.
   assign imem_req   = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_addr  = req_addr_q;
   assign CurrentPC  = pc_q;
   assign IFID_PC    = ifid_pc_q;
   assign IFID_Instr = ifid_instr_q;
   assign IFID_Valid = ifid_valid_q;

   // Fetch sequencer: PC, request address, hold buffer and IF/ID register.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q      <= START;
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         hold_pc_q    <= 64'h0;
         hold_instr_q <= BUBBLE_INSTR;
         ifid_pc_q    <= 64'h0;
         ifid_instr_q <= BUBBLE_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         case (state_q)
            START: begin
               // A redirect arriving before the first request retargets it.
               if (PCSrc) begin
                  pc_q       <= target_d;
                  req_addr_q <= target_d;
               end else begin
                  req_addr_q <= pc_q;
               end
               state_q <= FETCH;
            end
            FETCH: begin
               if (PCSrc) begin
                  ifid_valid_q <= 1'b0;
                  ifid_instr_q <= BUBBLE_INSTR;
                  pc_q         <= target_d;
                  // An unanswered request must stay on the bus until it completes.
                  if (imem_ready) begin
                     req_addr_q <= target_d;
                  end else begin
                     state_q <= DRAIN;
                  end
               end else if (imem_ready) begin
                  pc_q <= req_next_d;
                  if (Stall) begin
                     hold_pc_q    <= req_addr_q;
                     hold_instr_q <= imem_data;
                     state_q      <= HOLD;
                  end else begin
                     ifid_pc_q    <= req_addr_q;
                     ifid_instr_q <= imem_data;
                     ifid_valid_q <= 1'b1;
                     req_addr_q   <= req_next_d;
                  end
               end else if (!Stall) begin
                  ifid_valid_q <= 1'b0;
                  ifid_instr_q <= BUBBLE_INSTR;
               end
            end
            HOLD: begin
               if (PCSrc) begin
                  ifid_valid_q <= 1'b0;
                  ifid_instr_q <= BUBBLE_INSTR;
                  pc_q         <= target_d;
                  req_addr_q   <= target_d;
                  state_q      <= FETCH;
               end else if (!Stall) begin
                  ifid_pc_q    <= hold_pc_q;
                  ifid_instr_q <= hold_instr_q;
                  ifid_valid_q <= 1'b1;
                  req_addr_q   <= pc_q;
                  state_q      <= FETCH;
               end
            end
            DRAIN: begin
               // IF/ID stays a bubble; a newer redirect replaces the pending one.
               ifid_valid_q <= 1'b0;
               ifid_instr_q <= BUBBLE_INSTR;
               if (PCSrc) begin
                  pc_q <= target_d;
               end else if (imem_ready) begin
                  req_addr_q <= pc_q;
                  state_q    <= FETCH;
               end
            end
            default: state_q <= START;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_fetch_stage;

   localparam logic [63:0] RST_PC = 64'hFFFFFFFFFFFFFFF8;
   localparam logic [31:0] NOP    = 32'hD503201F;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [63:0] NextPC = 64'h0;
   logic        PCSrc = 1'b0;
   logic        Stall = 1'b0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_data;
   logic [63:0] CurrentPC;
   logic [63:0] IFID_PC;
   logic [31:0] IFID_Instr;
   logic        IFID_Valid;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_stage #(.RESET_PC(RST_PC), .BUBBLE_INSTR(NOP)) dut (
      .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .PCSrc(PCSrc), .Stall(Stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_data(imem_data), .CurrentPC(CurrentPC), .IFID_PC(IFID_PC),
      .IFID_Instr(IFID_Instr), .IFID_Valid(IFID_Valid)
   );

   always #5 CLK = ~CLK;

   // Instruction memory contents: a fixed hash of the address.
   function automatic logic [31:0] mem(input logic [63:0] a);
      if (a == 64'h8) return 32'h8B020020;
      return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
   endfunction

   assign imem_data = mem(imem_addr);

   // Reference model: "started" = first request issued; "holding" = a fetched
   // word parked while stalled; "draining" = old request owed before redirect.
   bit          m_started, m_holding, m_draining, m_just_reset;
   logic [63:0] m_pc, m_fetch;
   logic [63:0] h_pc;
   logic [31:0] h_ins;
   bit          o_vld;
   logic [63:0] o_pc;
   logic [31:0] o_ins;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic bubble();
      o_vld = 1'b0;
      o_ins = NOP;
   endtask

   task automatic model(input bit rst, rdy, stl, src, input logic [63:0] npc);
      logic [63:0] tgt;
      logic [31:0] word;
      tgt  = npc & ~64'h3;
      word = mem(m_fetch);
      m_just_reset = rst;
      if (rst) begin
         m_started = 0; m_holding = 0; m_draining = 0;
         m_pc = RST_PC; o_vld = 0; o_pc = 64'h0; o_ins = NOP;
      end else if (!m_started) begin
         m_started = 1;
         if (src) m_pc = tgt;
         m_fetch = m_pc;
      end else if (src) begin
         bubble();
         m_pc = tgt;
         if (m_holding) begin
            m_holding = 0; m_fetch = tgt;
         end else if (!m_draining) begin
            if (rdy) m_fetch = tgt;
            else m_draining = 1;
         end
      end else if (m_draining) begin
         if (rdy) begin
            m_draining = 0; m_fetch = m_pc;
         end
      end else if (m_holding) begin
         if (!stl) begin
            o_vld = 1; o_pc = h_pc; o_ins = h_ins;
            m_holding = 0; m_fetch = m_pc;
         end
      end else if (rdy) begin
         m_pc = m_fetch + 64'd4;
         if (stl) begin
            h_pc = m_fetch; h_ins = word; m_holding = 1;
         end else begin
            o_vld = 1; o_pc = m_fetch; o_ins = word;
            m_fetch = m_fetch + 64'd4;
         end
      end else if (!stl) begin
         bubble();
      end
   endtask

   // One clock: drive inputs at the falling edge, advance model, compare after.
   task automatic step(input bit rst, rdy, stl, src, input logic [63:0] npc);
      bit exp_req;
      Reset = rst; imem_ready = rdy; Stall = stl; PCSrc = src; NextPC = npc;
      model(rst, rdy, stl, src, npc);
      @(posedge CLK);
      @(negedge CLK);
      exp_req = m_started && !m_holding;
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_fetch);
      chk("CurrentPC", CurrentPC, m_pc);
      chk("IFID_Valid", 64'(IFID_Valid), 64'(o_vld));
      chk("IFID_Instr", 64'(IFID_Instr), 64'(o_ins));
      if (o_vld || m_just_reset) chk("IFID_PC", IFID_PC, o_pc);
   endtask

   initial begin
      @(negedge CLK);
      // Reset, then streaming fetch across the 2^64 wrap: F8, FC, 0, 4.
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
      // Memory wait states at 0x8.
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      // Redirect back to 0x8, then stall with a response pending in HOLD.
      step(0, 1, 0, 1, 64'h8);
      step(0, 1, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      // Redirect under stall with ready.
      step(0, 1, 1, 1, 64'h40);
      step(0, 1, 0, 0, 0);
      // Redirect while a request at 0x10 is unanswered: drain then 0x40.
      step(0, 1, 0, 1, 64'h10);
      step(0, 0, 0, 1, 64'h43);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 64'h43);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      // Reset during DRAIN; the late ready must be ignored.
      step(0, 0, 0, 1, 64'h20);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] npc;
         case ($urandom % 4)
            0:       npc = {$urandom, $urandom};
            1:       npc = 64'hFFFFFFFFFFFFFFF0 + 64'($urandom % 16);
            default: npc = 64'($urandom % 256);
         endcase
         step(($urandom % 200) == 0, ($urandom % 10) < 7, ($urandom % 4) == 0,
              ($urandom % 12) == 0, npc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
